// File: rtl/ula_ctrl.sv
// Multi-cycle issuing controller for the ULA: fetch, decode, one-cycle ALU issue,
// register write-back and flag-driven conditional jumps.
module ula_ctrl #(
  parameter int unsigned PC_W    = 8,
  parameter logic [3:0]  IDLE_OP = 4'b1111,
  localparam int unsigned DW     = 8,
  localparam int unsigned IW     = 16,
  localparam int unsigned RAW    = 2,
  localparam int unsigned OPW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [IW-1:0]   instr_data,
  output logic [RAW-1:0]  rf_ra_addr,
  output logic [RAW-1:0]  rf_rb_addr,
  input  logic [DW-1:0]   rf_ra_data,
  input  logic [DW-1:0]   rf_rb_data,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_zero,
  input  logic            alu_carry,
  input  logic            alu_neg,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_wa,
  output logic [DW-1:0]   rf_wd,
  output logic            busy,
  output logic            halted
);

  localparam logic [OPW-1:0] OPC_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OPC_SUB  = 4'b0001;
  localparam logic [OPW-1:0] OPC_LDI  = 4'b0010;
  localparam logic [OPW-1:0] OPC_SHL  = 4'b0101;
  localparam logic [OPW-1:0] OPC_SHR  = 4'b0110;
  localparam logic [OPW-1:0] OPC_JMP  = 4'b1000;
  localparam logic [OPW-1:0] OPC_JZ   = 4'b1001;
  localparam logic [OPW-1:0] OPC_JC   = 4'b1010;
  localparam logic [OPW-1:0] OPC_JN   = 4'b1011;
  localparam logic [OPW-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic            n_q, n_d;

  logic [OPW-1:0]  opc;
  logic [RAW-1:0]  rd;
  logic [RAW-1:0]  rs;
  logic [DW-1:0]   imm;
  logic            is_alu;
  logic            is_jump;
  logic            jump_taken;
  logic [PC_W-1:0] pc_inc;

  // Instruction fields decoded from the latched IR
  assign opc    = ir_q[15:12];
  assign rd     = ir_q[11:10];
  assign rs     = ir_q[9:8];
  assign imm    = ir_q[7:0];
  assign pc_inc = pc_q + PC_W'(1);

  assign is_alu  = (opc == OPC_ADD) || (opc == OPC_SUB) ||
                   (opc == OPC_SHL) || (opc == OPC_SHR);
  assign is_jump = (opc == OPC_JMP) || (opc == OPC_JZ) ||
                   (opc == OPC_JC)  || (opc == OPC_JN);

  // Conditional jumps resolve against the shadow flags, never the live ULA flags
  always_comb begin
    jump_taken = 1'b0;
    case (opc)
      OPC_JMP: jump_taken = 1'b1;
      OPC_JZ:  jump_taken = z_q;
      OPC_JC:  jump_taken = c_q;
      OPC_JN:  jump_taken = n_q;
      default: jump_taken = 1'b0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
    end
  end

  // Next-state, PC, IR and flag update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu) begin
          state_d = S_EXEC;
        end else if (opc == OPC_LDI) begin
          state_d = S_WB;
        end else if (opc == OPC_HALT) begin
          state_d = S_HALT;
        end else if (is_jump) begin
          state_d = S_FETCH;
          pc_d    = jump_taken ? PC_W'(imm) : pc_inc;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        // N only tracks subtraction; other ALU ops leave it alone
        if (is_alu) begin
          z_d = alu_zero;
          c_d = alu_carry;
          if (opc == OPC_SUB) n_d = alu_neg;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state so reset clears them at once
  always_comb begin
    alu_op     = IDLE_OP;
    alu_a      = '0;
    alu_b      = '0;
    rf_we      = 1'b0;
    rf_wd      = imm;
    rf_wa      = rd;
    rf_ra_addr = rd;
    rf_rb_addr = rs;
    instr_addr = pc_q;
    busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    halted     = (state_q == S_HALT);
    case (state_q)
      S_EXEC: begin
        alu_op = opc;
        alu_a  = rf_ra_data;
        alu_b  = rf_rb_data;
      end
      S_WB: begin
        rf_we = 1'b1;
        rf_wd = is_alu ? alu_result : imm;
      end
      default: begin
        alu_op = IDLE_OP;
      end
    endcase
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed bench for ula_ctrl with behavioural ROM, register file and ULA models.
module tb_ula_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [1:0]  rf_ra_addr, rf_rb_addr, rf_wa;
  logic [7:0]  rf_ra_data, rf_rb_data, rf_wd;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_carry, alu_neg;
  logic        rf_we, busy, halted;

  logic [15:0] rom [256];
  logic [7:0]  regs [4] = '{default: 8'h00};
  int          wr_cnt = 0;
  int          live_cnt = 0;
  logic [3:0]  last_op = 4'h0;
  logic [7:0]  last_a = 8'h00;
  logic [7:0]  last_b = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ula_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_neg(alu_neg),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .halted(halted)
  );

  assign instr_data = rom[instr_addr];
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      regs[rf_wa] <= rf_wd;
      wr_cnt      <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (alu_op !== 4'hF) begin
      live_cnt = live_cnt + 1;
      last_op  = alu_op;
      last_a   = alu_a;
      last_b   = alu_b;
    end
  end

  // ULA reference: registered result/flags, IDLE op holds
  always @(posedge clk or negedge rst_n) begin : ula_model
    logic [8:0] s;
    if (!rst_n) begin
      alu_result <= 8'h00;
      alu_zero   <= 1'b1;
      alu_carry  <= 1'b0;
      alu_neg    <= 1'b0;
    end else begin
      s = 9'h000;
      case (alu_op)
        4'b0000: s = {1'b0, alu_a} + {1'b0, alu_b};
        4'b0001: s = {1'b0, alu_a} - {1'b0, alu_b};
        4'b0101: s = {alu_a, 1'b0};
        4'b0110: s = {alu_a[0], 1'b0, alu_a[7:1]};
        default: s = 9'h000;
      endcase
      if (alu_op == 4'b0000 || alu_op == 4'b0001 || alu_op == 4'b0101 || alu_op == 4'b0110) begin
        alu_result <= s[7:0];
        alu_carry  <= s[8];
        alu_zero   <= (s[7:0] == 8'h00);
        alu_neg    <= s[7];
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] o, input logic [1:0] d,
                                      input logic [1:0] s, input logic [7:0] i);
    return {o, d, s, i};
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'hF000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (halted === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clear_rom();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (alu_op !== 4'hF) begin n_err++; $display("FAIL rst_alu_op got=%h exp=f", alu_op); end
    n_vec++; if ({alu_a, alu_b} !== 16'h0000) begin n_err++; $display("FAIL rst_alu_ab got=%h exp=0000", {alu_a, alu_b}); end
    n_vec++; if ({rf_we, busy, halted} !== 3'b000) begin n_err++; $display("FAIL rst_we_busy_halt got=%b exp=000", {rf_we, busy, halted}); end
    n_vec++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL rst_pc got=%h exp=00", instr_addr); end
    apply_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_add();
    int cyc; bit to; int live0;
    apply_reset();
    clear_rom();
    rom[0] = enc(4'b0010, 2'd0, 2'd0, 8'h05);
    rom[1] = enc(4'b0010, 2'd1, 2'd0, 8'h03);
    rom[2] = enc(4'b0000, 2'd0, 2'd1, 8'h00);
    rom[3] = enc(4'b1001, 2'd0, 2'd0, 8'h40);
    rom[4] = enc(4'b1010, 2'd0, 2'd0, 8'h40);
    live0 = live_cnt;
    pulse_start();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got=%b exp=1", busy); end
    wait_halt(cyc, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t1_timeout got=timeout exp=halt"); end
    n_vec++; if (regs[0] !== 8'h08) begin n_err++; $display("FAIL t1_r0 got=%h exp=08", regs[0]); end
    n_vec++; if (regs[1] !== 8'h03) begin n_err++; $display("FAIL t1_r1 got=%h exp=03", regs[1]); end
    n_vec++; if (live_cnt - live0 !== 1) begin n_err++; $display("FAIL t1_live_ops got=%0d exp=1", live_cnt - live0); end
    n_vec++; if ({last_op, last_a, last_b} !== {4'h0, 8'h05, 8'h03}) begin n_err++; $display("FAIL t1_issue got=%h exp=00503", {last_op, last_a, last_b}); end
    n_vec++; if (instr_addr !== 8'h05) begin n_err++; $display("FAIL t1_zc_fallthru_pc got=%h exp=05", instr_addr); end
    n_vec++; if (cyc !== 16) begin n_err++; $display("FAIL t1_cycles got=%0d exp=16", cyc); end
    n_vec++; if ({busy, halted} !== 2'b01) begin n_err++; $display("FAIL t1_halt_state got=%b exp=01", {busy, halted}); end
  endtask

  task automatic test_sub_jn();
    int cyc; bit to;
    apply_reset();
    clear_rom();
    rom[0] = enc(4'b0010, 2'd0, 2'd0, 8'h03);
    rom[1] = enc(4'b0010, 2'd1, 2'd0, 8'h05);
    rom[2] = enc(4'b0001, 2'd0, 2'd1, 8'h00);
    rom[3] = enc(4'b1011, 2'd0, 2'd0, 8'h20);
    pulse_start();
    wait_halt(cyc, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t2_timeout got=timeout exp=halt"); end
    n_vec++; if (regs[0] !== 8'hFE) begin n_err++; $display("FAIL t2_r0 got=%h exp=fe", regs[0]); end
    n_vec++; if (last_op !== 4'b0001) begin n_err++; $display("FAIL t2_op got=%b exp=0001", last_op); end
    n_vec++; if (instr_addr !== 8'h20) begin n_err++; $display("FAIL t2_jn_pc got=%h exp=20", instr_addr); end
    n_vec++; if (cyc !== 14) begin n_err++; $display("FAIL t2_cycles got=%0d exp=14", cyc); end
  endtask

  task automatic test_shl_flags();
    int cyc; bit to; int live0;
    apply_reset();
    clear_rom();
    rom[0]     = enc(4'b0010, 2'd3, 2'd0, 8'h7F);
    rom[1]     = enc(4'b0010, 2'd0, 2'd0, 8'h01);
    rom[2]     = enc(4'b0000, 2'd3, 2'd0, 8'h00);
    rom[3]     = enc(4'b0010, 2'd2, 2'd0, 8'h80);
    rom[4]     = enc(4'b0101, 2'd2, 2'd2, 8'h00);
    rom[5]     = enc(4'b1001, 2'd0, 2'd0, 8'h10);
    rom[8'h10] = enc(4'b1010, 2'd0, 2'd0, 8'h18);
    rom[8'h18] = enc(4'b1011, 2'd0, 2'd0, 8'h30);
    live0 = live_cnt;
    pulse_start();
    wait_halt(cyc, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t3_timeout got=timeout exp=halt"); end
    n_vec++; if (regs[3] !== 8'h80) begin n_err++; $display("FAIL t3_r3 got=%h exp=80", regs[3]); end
    n_vec++; if (regs[2] !== 8'h00) begin n_err++; $display("FAIL t3_r2 got=%h exp=00", regs[2]); end
    n_vec++; if ({last_op, last_a} !== {4'b0101, 8'h80}) begin n_err++; $display("FAIL t3_issue got=%h exp=580", {last_op, last_a}); end
    n_vec++; if (live_cnt - live0 !== 2) begin n_err++; $display("FAIL t3_live_ops got=%0d exp=2", live_cnt - live0); end
    n_vec++; if (instr_addr !== 8'h19) begin n_err++; $display("FAIL t3_path_pc got=%h exp=19", instr_addr); end
    n_vec++; if (cyc !== 25) begin n_err++; $display("FAIL t3_cycles got=%0d exp=25", cyc); end
  endtask

  task automatic test_pc_wrap();
    int cyc; bit to; bit seen;
    apply_reset();
    clear_rom();
    rom[0]     = enc(4'b1010, 2'd0, 2'd0, 8'h10);
    rom[1]     = enc(4'b0010, 2'd0, 2'd0, 8'h80);
    rom[2]     = enc(4'b0101, 2'd0, 2'd0, 8'h00);
    rom[3]     = enc(4'b1000, 2'd0, 2'd0, 8'hFF);
    rom[8'hFF] = enc(4'b0011, 2'd0, 2'd0, 8'h00);
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (instr_addr === 8'hFF) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL t4_reach_ff got=timeout exp=pc_ff"); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL t4_wrap got=%h exp=00", instr_addr); end
    wait_halt(cyc, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t4_timeout got=timeout exp=halt"); end
    n_vec++; if (instr_addr !== 8'h10) begin n_err++; $display("FAIL t4_jc_pc got=%h exp=10", instr_addr); end
  endtask

  task automatic test_reset_in_wb();
    int we_seen; int wr0;
    apply_reset();
    clear_rom();
    rom[0] = enc(4'b0010, 2'd0, 2'd0, 8'h05);
    rom[1] = enc(4'b0010, 2'd1, 2'd0, 8'h03);
    rom[2] = enc(4'b0000, 2'd0, 2'd1, 8'h00);
    wr0 = wr_cnt;
    we_seen = 0;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      if (rf_we === 1'b1) we_seen++;
      if (we_seen == 3) break;
      @(negedge clk);
    end
    n_vec++; if (we_seen != 3) begin n_err++; $display("FAIL t5_reach_wb got=%0d exp=3", we_seen); end
    n_vec++; if (alu_result !== 8'h08) begin n_err++; $display("FAIL t5_pending_result got=%h exp=08", alu_result); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t5_we_drop got=%b exp=0", rf_we); end
    n_vec++; if ({busy, halted, instr_addr} !== 10'h000) begin n_err++; $display("FAIL t5_idle got=%h exp=000", {busy, halted, instr_addr}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (wr_cnt - wr0 !== 2) begin n_err++; $display("FAIL t5_writes got=%0d exp=2", wr_cnt - wr0); end
    n_vec++; if (regs[0] !== 8'h05) begin n_err++; $display("FAIL t5_r0 got=%h exp=05", regs[0]); end
    n_vec++; if ({busy, alu_op} !== 5'h0F) begin n_err++; $display("FAIL t5_post_idle got=%h exp=0f", {busy, alu_op}); end
  endtask

  task automatic test_halt_sticky();
    int cyc; bit to; int wr0; int live0;
    apply_reset();
    clear_rom();
    pulse_start();
    wait_halt(cyc, to);
    n_vec++; if (to || cyc !== 2) begin n_err++; $display("FAIL t6_halt_cycles got=%0d exp=2", cyc); end
    wr0 = wr_cnt;
    live0 = live_cnt;
    for (int k = 0; k < 6; k++) begin
      start = ~start;
      @(posedge clk);
      @(negedge clk);
      n_vec++; if ({halted, busy, alu_op} !== 6'b10_1111) begin n_err++; $display("FAIL t6_sticky got=%b exp=101111", {halted, busy, alu_op}); end
    end
    start = 1'b0;
    n_vec++; if (wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL t6_writes got=%0d exp=0", wr_cnt - wr0); end
    n_vec++; if (live_cnt - live0 !== 0) begin n_err++; $display("FAIL t6_live_ops got=%0d exp=0", live_cnt - live0); end
    n_vec++; if (instr_addr !== 8'h00) begin n_err++; $display("FAIL t6_pc got=%h exp=00", instr_addr); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_jn();
    test_shl_flags();
    test_pc_wrap();
    test_reset_in_wb();
    test_halt_sticky();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
